regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the 32x32 register file's single write port among NREQ writeback requesters
//   (ALU, load unit, debug port).
//   - Round-robin arbitration with a valid/ready handshake.
//   - Winner is registered into one output stage that drives RegWrite/Wt_addr/Wt_data.
//   - Optionally forwards the in-flight write onto the two read ports.
// PARAMETERS
//   NREQ  3   number of writeback requesters (2..8)
//   AW    5   register address width
//   DW    32  register data width
// PORTS
//   clk          in   1         rising-edge clock
//   rst          in   1         synchronous, active-high reset
//   req_valid    in   NREQ      requester i has a pending write
//   req_addr     in   NREQ*AW   packed; slice i = [i*AW +: AW]
//   req_data     in   NREQ*DW   packed; slice i = [i*DW +: DW]
//   req_ready    out  NREQ      one-hot (or zero) grant; transfer when valid&ready
//   wb_stall     in   1         freeze arbitration; no grants while high
//   RegWrite     out  1         register-file write enable
//   Wt_addr      out  AW        register-file write address
//   Wt_data      out  DW        register-file write data
//   rs1_addr     in   AW        decode read address 1
//   rs2_addr     in   AW        decode read address 2
//   rf_rs1_data  in   DW        raw register-file Rs1_data
//   rf_rs2_data  in   DW        raw register-file Rs2_data
//   fwd_rs1_data out  DW        read data 1 (forwarded or raw)
//   fwd_rs2_data out  DW        read data 2 (forwarded or raw)
// BEHAVIOUR
//   - Reset: RegWrite=0, Wt_addr=0, Wt_data=0, req_ready=0, last_grant=NREQ-1 (req0 highest priority).
//   - req_ready is combinational.
//     - Search starts at (last_grant+1) mod NREQ and wraps; the first valid index wins.
//     - req_ready = onehot(winner) when any req_valid && !wb_stall && !rst, else 0.
//   - Handshake:
//     - A requester holds valid, addr and data stable until it sees ready.
//     - Dropping valid before ready is illegal (bench assertion).
//   - Grant at edge N:
//     - last_grant <= winner.
//     - Wt_addr/Wt_data <= winner's slices.
//     - RegWrite <= (addr != 0).
//     - Write lands in the register file at edge N+1. Latency: handshake cycle + 1.
//   - No grant in a cycle (no valid, or stall): RegWrite <= 0. Wt_addr/Wt_data hold their last values.
//   - Write to x0:
//     - Granted and consumed normally (ready pulses).
//     - RegWrite stays 0 and the write is silently dropped.
//   - Simultaneous valids: exactly one grant per cycle.
//     - Strict rotation; each requester waits at most NREQ-1 cycles.
//   - Same address from two requesters: register-file order equals grant order.
//   - wb_stall:
//     - Blocks new grants only. A write already in the output stage still completes.
//     - last_grant is unchanged during a stall.
//   - rst mid-operation: the in-flight write is discarded (RegWrite=0 on the next cycle) and the pointer is reset.
// CONFIGURATION
//   `WB_FWD_EN defined:
//     - fwd_rsK_data = Wt_data when RegWrite && Wt_addr == rsK_addr && rsK_addr != 0.
//     - Otherwise fwd_rsK_data = rf_rsK_data.
//     - Purely combinational; covers the cycle before the write lands.
//   `WB_FWD_EN undefined:
//     - fwd_rsK_data = rf_rsK_data (pass-through).
//     - Ports remain present in both builds.
// STRUCTURE
//   - Package regfile_pkg:
//     - REG_AW=5, REG_DW=32, X0_ADDR=5'd0.
//     - Requester indices REQ_ALU=0, REQ_MEM=1, REQ_DBG=2.
//   - Sub-module rr_arbiter #(N):
//     - Inputs: req, enable. Output: one-hot gnt.
//     - Holds the last_grant pointer; pointer updates only when gnt != 0.
//   - Top module: output stage, x0 filter, forwarding mux.
// TESTING
//   1 Reset: hold rst 2 cycles with all valid -> req_ready=0, RegWrite=0; first grant after release is req0.
//   2 Single write: req1 valid, addr=5, data=0xDEADBEEF
//     -> ready[1] that cycle; next cycle RegWrite=1, Wt_addr=5, Wt_data=0xDEADBEEF.
//   3 Contention: all 3 valid continuously for 6 cycles -> grants 0,1,2,0,1,2; RegWrite high 6 consecutive cycles.
//   4 x0: req0 writes addr=0, data=0x1234 -> ready[0]=1; RegWrite stays 0; Rs1 of x0 reads 0.
//   5 Stall: all valid, wb_stall high 3 cycles after grant to req0
//     -> no ready for 3 cycles; req1 granted first after release.
//   6 WB_FWD_EN: grant addr=7, data=0xA5A5A5A5; next cycle rs1_addr=7, rf_rs1_data=0
//     -> fwd_rs1_data=0xA5A5A5A5 (0 when macro undefined).

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: register geometry,
// the hard-wired zero register, and the requester index map.
package regfile_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    localparam logic [REG_AW-1:0] X0_ADDR = 5'd0;

    // Fixed slot of each writeback source on the arbiter inputs.
    typedef enum int {
        REQ_ALU = 0,
        REQ_MEM = 1,
        REQ_DBG = 2
    } req_id_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester found after the
// previous winner, wrapping around. The pointer moves only when a grant is issued.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         enable,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] last_grant;
    logic [PW-1:0] win_idx;
    logic          found;
    int            cand;

    // Scan from the slot after the last winner and grant the first valid one.
    always_comb begin
        gnt     = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (enable && !found && req[PW'(cand)]) begin
                gnt[PW'(cand)] = 1'b1;
                win_idx        = PW'(cand);
                found          = 1'b1;
            end
        end
    end

    // Remember the winner; reset parks the pointer on the last slot so slot 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PW'(N - 1);
        end else if (|gnt) begin
            last_grant <= win_idx;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register file: round-robin selects one
// requester per cycle, registers it into the write stage, suppresses writes
// to x0, and optionally forwards the in-flight write to the read ports.
// Optional feature macro: WB_FWD_EN (read-port forwarding of the pending write).
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               wb_stall,
    output logic               RegWrite,
    output logic [AW-1:0]      Wt_addr,
    output logic [DW-1:0]      Wt_data,
    input  logic [AW-1:0]      rs1_addr,
    input  logic [AW-1:0]      rs2_addr,
    input  logic [DW-1:0]      rf_rs1_data,
    input  logic [DW-1:0]      rf_rs2_data,
    output logic [DW-1:0]      fwd_rs1_data,
    output logic [DW-1:0]      fwd_rs2_data
);

    logic          arb_enable;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    assign arb_enable = !wb_stall && !rst;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .enable (arb_enable),
        .gnt    (req_ready)
    );

    // The grant is one-hot, so an AND-OR mux picks the winner's address and data.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = sel_addr | req_addr[i*AW +: AW];
                sel_data = sel_data | req_data[i*DW +: DW];
            end
        end
    end

    // Output stage: capture the winner; x0 writes are consumed but never enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite <= 1'b0;
            Wt_addr  <= '0;
            Wt_data  <= '0;
        end else if (|req_ready) begin
            RegWrite <= (sel_addr != AW'(X0_ADDR));
            Wt_addr  <= sel_addr;
            Wt_data  <= sel_data;
        end else begin
            RegWrite <= 1'b0;
        end
    end

`ifdef WB_FWD_EN
    // Bypass the register file when a read hits the write that lands next edge.
    always_comb begin
        fwd_rs1_data = rf_rs1_data;
        fwd_rs2_data = rf_rs2_data;
        if (RegWrite && (Wt_addr == rs1_addr) && (rs1_addr != AW'(X0_ADDR))) begin
            fwd_rs1_data = Wt_data;
        end
        if (RegWrite && (Wt_addr == rs2_addr) && (rs2_addr != AW'(X0_ADDR))) begin
            fwd_rs2_data = Wt_data;
        end
    end
`else
    logic unused_rs;
    assign unused_rs = ^{rs1_addr, rs2_addr};

    // Without forwarding the read ports pass the raw register-file data through.
    always_comb begin
        fwd_rs1_data = rf_rs1_data;
        fwd_rs2_data = rf_rs2_data;
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the arbiter.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = REG_AW;
    localparam int DW   = REG_DW;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               wb_stall;
    logic               RegWrite;
    logic [AW-1:0]      Wt_addr;
    logic [DW-1:0]      Wt_data;
    logic [AW-1:0]      rs1_addr;
    logic [AW-1:0]      rs2_addr;
    logic [DW-1:0]      rf_rs1_data;
    logic [DW-1:0]      rf_rs2_data;
    logic [DW-1:0]      fwd_rs1_data;
    logic [DW-1:0]      fwd_rs2_data;

    int passed = 0;
    int total  = 0;

    int            m_last;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            last_winner;

    logic          pend      [NREQ];
    logic [AW-1:0] pend_addr [NREQ];
    logic [DW-1:0] pend_data [NREQ];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wb_stall     (wb_stall),
        .RegWrite     (RegWrite),
        .Wt_addr      (Wt_addr),
        .Wt_data      (Wt_data),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rf_rs1_data  (rf_rs1_data),
        .rf_rs2_data  (rf_rs2_data),
        .fwd_rs1_data (fwd_rs1_data),
        .fwd_rs2_data (fwd_rs2_data)
    );

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive the requester side of the arbiter.
    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a,
                                 input logic [NREQ*DW-1:0] d, input logic st, input logic r);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        wb_stall  = st;
        rst       = r;
    endtask

    // Reference winner: first valid requester after the previous winner, wrapping.
    function automatic int modelWinner();
        int idx;
        if (rst || wb_stall) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (m_last + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] modelFwd(input logic [AW-1:0] ra, input logic [DW-1:0] raw);
`ifdef WB_FWD_EN
        if (m_we && (m_addr == ra) && (ra != 0)) return m_data;
`endif
        return raw;
    endfunction

    // Check all outputs for the current cycle, then advance the model across the edge.
    task automatic evalCycle(input string tag);
        int w;
        logic [NREQ-1:0] exp_ready;
        #1;
        w = modelWinner();
        exp_ready = (w >= 0) ? (NREQ'(1) << w) : '0;
        checkOutput({tag, "_ready"},    64'(req_ready),    64'(exp_ready));
        checkOutput({tag, "_regwrite"}, 64'(RegWrite),     64'(m_we));
        checkOutput({tag, "_wt_addr"},  64'(Wt_addr),      64'(m_addr));
        checkOutput({tag, "_wt_data"},  64'(Wt_data),      64'(m_data));
        checkOutput({tag, "_fwd1"},     64'(fwd_rs1_data), 64'(modelFwd(rs1_addr, rf_rs1_data)));
        checkOutput({tag, "_fwd2"},     64'(fwd_rs2_data), 64'(modelFwd(rs2_addr, rf_rs2_data)));
        last_winner = w;
        @(posedge clk);
        if (rst) begin
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
            m_last = NREQ - 1;
        end else if (w >= 0) begin
            m_last = w;
            m_addr = req_addr[w*AW +: AW];
            m_data = req_data[w*DW +: DW];
            m_we   = (m_addr != 0);
        end else begin
            m_we = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [NREQ-1:0] v;
        logic [NREQ*AW-1:0] a;
        logic [NREQ*DW-1:0] d;

        rs1_addr = '0; rs2_addr = '0; rf_rs1_data = '0; rf_rs2_data = '0;
        applyStimulus('1, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 1'b0, 1'b1);
        m_we = 1'b0; m_addr = '0; m_data = '0; m_last = NREQ - 1;
        @(posedge clk);
        @(negedge clk);

        // Reset held with every requester valid.
        $display("[TB] reset");
        evalCycle("t1_rst_a");
        evalCycle("t1_rst_b");
        rst = 1'b0;
        #1 checkOutput("t1_first_grant", 64'(req_ready), 64'(3'b001));
        evalCycle("t1_rel");

        // Single write from the load unit.
        $display("[TB] single write");
        applyStimulus(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 1'b0, 1'b0);
        #1 checkOutput("t2_ready", 64'(req_ready[REQ_MEM]), 64'(1'b1));
        evalCycle("t2_grant");
        applyStimulus('0, req_addr, req_data, 1'b0, 1'b0);
        #1;
        checkOutput("t2_we",   64'(RegWrite), 64'(1'b1));
        checkOutput("t2_addr", 64'(Wt_addr),  64'(5'd5));
        checkOutput("t2_data", 64'(Wt_data),  64'(32'hDEADBEEF));
        evalCycle("t2_land");

        // Contention: all three valid for six cycles.
        $display("[TB] contention");
        rst = 1'b1; evalCycle("t3_rst");
        applyStimulus('1, {5'd3, 5'd2, 5'd1}, {32'hC3, 32'hC2, 32'hC1}, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            #1 checkOutput($sformatf("t3_gnt%0d", i), 64'(req_ready), 64'(3'b001 << (i % 3)));
            if (i > 0) checkOutput($sformatf("t3_we%0d", i), 64'(RegWrite), 64'(1'b1));
            evalCycle($sformatf("t3_c%0d", i));
        end
        applyStimulus('0, req_addr, req_data, 1'b0, 1'b0);
        #1 checkOutput("t3_we_last", 64'(RegWrite), 64'(1'b1));
        evalCycle("t3_drain");

        // Write to x0 is consumed but never enabled.
        $display("[TB] x0 write");
        rst = 1'b1; evalCycle("t4_rst");
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234}, 1'b0, 1'b0);
        #1 checkOutput("t4_ready", 64'(req_ready), 64'(3'b001));
        evalCycle("t4_grant");
        applyStimulus('0, req_addr, req_data, 1'b0, 1'b0);
        rs1_addr = '0; rf_rs1_data = '0;
        #1;
        checkOutput("t4_we",   64'(RegWrite),     64'(1'b0));
        checkOutput("t4_rs1",  64'(fwd_rs1_data), 64'(32'h0));
        evalCycle("t4_after");

        // Stall after a grant to req0.
        $display("[TB] stall");
        rst = 1'b1; evalCycle("t5_rst");
        applyStimulus('1, {5'd9, 5'd8, 5'd7}, {32'h59, 32'h58, 32'h57}, 1'b0, 1'b0);
        #1 checkOutput("t5_gnt0", 64'(req_ready), 64'(3'b001));
        evalCycle("t5_g0");
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput($sformatf("t5_stall%0d", i), 64'(req_ready), 64'(3'b000));
            evalCycle($sformatf("t5_s%0d", i));
        end
        wb_stall = 1'b0;
        #1 checkOutput("t5_resume", 64'(req_ready), 64'(3'b010));
        evalCycle("t5_r");
        applyStimulus('0, req_addr, req_data, 1'b0, 1'b0);
        evalCycle("t5_idle");

        // Forwarding of the in-flight write.
        $display("[TB] forwarding");
        applyStimulus(3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'hA5A5A5A5}, 1'b0, 1'b0);
        evalCycle("t6_grant");
        applyStimulus('0, req_addr, req_data, 1'b0, 1'b0);
        rs1_addr = 5'd7; rf_rs1_data = '0;
`ifdef WB_FWD_EN
        #1 checkOutput("t6_fwd", 64'(fwd_rs1_data), 64'(32'hA5A5A5A5));
`else
        #1 checkOutput("t6_fwd", 64'(fwd_rs1_data), 64'(32'h0));
`endif
        evalCycle("t6_land");

        // Random traffic with held-until-ready requests, stalls and occasional reset.
        $display("[TB] random");
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i]      = 1'b1;
                    pend_addr[i] = AW'($urandom_range(0, 7));
                    pend_data[i] = $urandom;
                end
                v[i]           = pend[i];
                a[i*AW +: AW]  = pend_addr[i];
                d[i*DW +: DW]  = pend_data[i];
            end
            applyStimulus(v, a, d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
            rs1_addr    = AW'($urandom_range(0, 7));
            rs2_addr    = AW'($urandom_range(0, 7));
            rf_rs1_data = $urandom;
            rf_rs2_data = $urandom;
            evalCycle("rnd");
            if (last_winner >= 0) pend[last_winner] = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
